// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared FP flag, writeback-entry and NaN-box definitions
package riscv_pkg;

  // Accrued exception flags in fflags bit order (nv is bit 4, nx is bit 0).
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  // Lifecycle of one in-order writeback slot.
  typedef enum logic [1:0] {
    ENT_EMPTY = 2'd0,
    ENT_WAIT  = 2'd1,
    ENT_DONE  = 2'd2
  } wb_entry_state_t;

  // Single-precision values in a wider FP register carry all-ones above bit 31.
  localparam logic NAN_BOX_FILL = 1'b1;
  localparam int   NAN_BOX_LSB  = 32;

endpackage

// File: rtl/fp_cmp_wb_buffer.sv
// rtl/fp_cmp_wb_buffer.sv - in-order writeback buffer for the FP compare unit
module fp_cmp_wb_buffer
  import riscv_pkg::*;
#(
  parameter int FP_WIDTH = 32,
  parameter int FLEN     = 64,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic            i_issue_single,
  output logic            o_issue_ready,
  input  logic            i_res_valid,
  input  logic [FP_WIDTH-1:0] i_res_data,
  input  logic            i_res_is_compare,
  input  fp_flags_t       i_res_flags,
  output logic            o_int_wr_valid,
  output logic [4:0]      o_int_wr_rd,
  output logic [XLEN-1:0] o_int_wr_data,
  input  logic            i_int_wr_ready,
  output logic            o_fp_wr_valid,
  output logic [4:0]      o_fp_wr_rd,
  output logic [FLEN-1:0] o_fp_wr_data,
  input  logic            i_fp_wr_ready,
  input  logic            i_flush,
  input  logic            i_fflags_clear,
  output fp_flags_t       o_fflags,
  output logic            o_proto_err
);

  localparam int PW  = $clog2(DEPTH);
  // Drop counter is wider than a pointer so back-to-back flushes can stack up.
  localparam int DW  = PW + 4;
  localparam int EW0 = (FLEN > XLEN) ? FLEN : XLEN;
  localparam int EW  = (FP_WIDTH > EW0) ? FP_WIDTH : EW0;

  typedef logic [PW:0] ptr_t;

  wb_entry_state_t     state_q  [DEPTH];
  logic [4:0]          rd_q     [DEPTH];
  logic                single_q [DEPTH];
  logic [FP_WIDTH-1:0] data_q   [DEPTH];
  logic                cmp_q    [DEPTH];
  fp_flags_t           flags_q  [DEPTH];

  ptr_t            head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [DW-1:0]   drop_q, drop_d;
  fp_flags_t       fflags_q, fflags_d;
  logic            proto_q, proto_d;

  logic [PW-1:0]   head_idx, tail_idx, fill_idx;
  ptr_t            count, wait_cnt;
  logic            has_wait, head_done;
  logic            issue_fire, drain_fire, res_fill, res_drop, res_stray;
  logic [DW-1:0]   pending;
  logic [EW-1:0]   res_ext;
  logic            box;

  assign head_idx   = head_q[PW-1:0];
  assign tail_idx   = tail_q[PW-1:0];
  assign fill_idx   = fill_q[PW-1:0];
  assign count      = tail_q - head_q;
  assign wait_cnt   = tail_q - fill_q;
  assign has_wait   = (wait_cnt != '0);
  assign head_done  = (state_q[head_idx] == ENT_DONE);

  assign o_issue_ready  = (count != ptr_t'(DEPTH)) && !i_flush;
  assign o_int_wr_valid = head_done && cmp_q[head_idx];
  assign o_fp_wr_valid  = head_done && !cmp_q[head_idx];
  assign o_int_wr_rd    = rd_q[head_idx];
  assign o_fp_wr_rd     = rd_q[head_idx];
  assign o_fflags       = fflags_q;
  assign o_proto_err    = proto_q;

  assign issue_fire = i_issue_valid && o_issue_ready;
  assign drain_fire = !i_flush && ((o_int_wr_valid && i_int_wr_ready) ||
                                   (o_fp_wr_valid && i_fp_wr_ready));
  // Results still owed by the compare unit that no entry will claim after a flush.
  assign pending    = drop_q + DW'(wait_cnt);
  assign res_drop   = i_res_valid && (drop_q != '0);
  assign res_fill   = i_res_valid && (drop_q == '0) && has_wait && !i_flush;
  assign res_stray  = i_res_valid && (drop_q == '0) && !has_wait;

  // Head result formatting: zero-extend for the integer port, NaN-box singles for FP.
  always_comb begin
    res_ext = '0;
    res_ext[FP_WIDTH-1:0] = data_q[head_idx];
    o_int_wr_data = res_ext[XLEN-1:0];
    box = single_q[head_idx] && (FLEN > NAN_BOX_LSB);
    o_fp_wr_data = '0;
    for (int i = 0; i < FLEN; i++) begin
      o_fp_wr_data[i] = (box && i >= NAN_BOX_LSB) ? NAN_BOX_FILL : res_ext[i];
    end
  end

  // Pointer, drop-counter and sticky-status next state.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    drop_d   = drop_q;
    proto_d  = proto_q || res_stray;
    fflags_d = i_fflags_clear ? '0 : fflags_q;
    if (drain_fire) begin
      fflags_d = fflags_d | flags_q[head_idx];
    end
    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      drop_d = pending - DW'(i_res_valid && (pending != '0));
    end else begin
      if (issue_fire) tail_d = tail_q + ptr_t'(1);
      if (res_fill)   fill_d = fill_q + ptr_t'(1);
      if (drain_fire) head_d = head_q + ptr_t'(1);
      if (res_drop)   drop_d = drop_q - DW'(1);
    end
  end

  // Register control state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
      fflags_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
      fflags_q <= fflags_d;
      proto_q  <= proto_d;
    end
  end

  // Entry array: allocate at tail, fill oldest WAIT, free head on drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]  <= ENT_EMPTY;
        rd_q[i]     <= '0;
        single_q[i] <= 1'b0;
        data_q[i]   <= '0;
        cmp_q[i]    <= 1'b0;
        flags_q[i]  <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ENT_EMPTY;
      end
    end else begin
      if (issue_fire) begin
        state_q[tail_idx]  <= ENT_WAIT;
        rd_q[tail_idx]     <= i_issue_rd;
        single_q[tail_idx] <= i_issue_single;
      end
      if (res_fill) begin
        state_q[fill_idx] <= ENT_DONE;
        data_q[fill_idx]  <= i_res_data;
        cmp_q[fill_idx]   <= i_res_is_compare;
        flags_q[fill_idx] <= i_res_flags;
      end
      if (drain_fire) begin
        state_q[head_idx] <= ENT_EMPTY;
      end
    end
  end

endmodule
